// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- MEM/WB pipeline register stage.
//
// Purpose:
//   Picks the writeback value from the ALU result, formatted load data or
//   PC+4, based on an explicit result-select code. Load data is formatted
//   by size, sign and byte offset. Data memory may answer late: the stage
//   then stalls upstream and parks the load's metadata until dmem_rvalid
//   arrives. The registered wb_* outputs feed both the register-file write
//   port and the forwarding unit.
//
// Optional feature (macro LOAD_TIMEOUT_EN):
//   When it is defined, a load that waits TIMEOUT_CYCLES cycles in WAIT
//   without data is abandoned. wb_load_err then pulses for one cycle and no
//   register write takes place. When it is undefined, WAIT lasts until data
//   arrives and wb_load_err is tied to 0.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             kill the instruction in MEM and any pending load
//   mem_valid         an instruction is present in MEM
//   mem_alu_result    ALU result / load address (bits [1:0] = byte offset)
//   mem_pc_plus4      return address for JAL/JALR
//   mem_result_src    00 ALU, 01 load, 10 PC+4, 11 ALU
//   mem_funct3        load type
//   mem_reg_dest      destination register
//   mem_reg_write     register write enable
//   dmem_rdata        read data word from memory
//   dmem_rvalid       read data valid this cycle
//   mem_stall         combinational; hold IF..MEM this cycle
//   wb_valid          wb_* holds a retiring instruction
//   wb_data           writeback data
//   wb_reg_dest       destination register
//   wb_reg_write      qualified write enable (never set for x0)
//   wb_load_err       one-cycle pulse on load timeout

module mem_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      mem_valid,
    input  logic [DATA_WIDTH-1:0]     mem_alu_result,
    input  logic [DATA_WIDTH-1:0]     mem_pc_plus4,
    input  logic [1:0]                mem_result_src,
    input  logic [2:0]                mem_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] mem_reg_dest,
    input  logic                      mem_reg_write,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    input  logic                      dmem_rvalid,
    output logic                      mem_stall,
    output logic                      wb_valid,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg_dest,
    output logic                      wb_reg_write,
    output logic                      wb_load_err
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      w_is_load;
    logic                      w_timeout;
    logic [DATA_WIDTH-1:0]     w_idle_data;

    logic                      r_wb_valid;
    logic [DATA_WIDTH-1:0]     r_wb_data;
    logic [REG_ADDR_WIDTH-1:0] r_wb_reg_dest;
    logic                      r_wb_reg_write;

    // Metadata of a load that is waiting for memory.
    logic [2:0]                r_hold_funct3;
    logic [1:0]                r_hold_offset;
    logic [REG_ADDR_WIDTH-1:0] r_hold_dest;
    logic                      r_hold_reg_write;

    // Formats a load by funct3. Halfwords use addr[1] only, so a misaligned
    // halfword still reads its aligned half. Unknown codes return the full word.
    function automatic logic [DATA_WIDTH-1:0] format_load(
        input logic [2:0]            funct3,
        input logic [1:0]            offset,
        input logic [DATA_WIDTH-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*offset +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  format_load = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b100:  format_load = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b001:  format_load = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b101:  format_load = {{(DATA_WIDTH-16){1'b0}}, h};
            default: format_load = word;
        endcase
    endfunction

    assign w_is_load = mem_valid && (mem_result_src == 2'b01);

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_load_err;

    // Timeout fires in the TIMEOUT_CYCLES-th WAIT cycle if data has still not come.
    assign w_timeout = (r_state == ST_WAIT) && !dmem_rvalid &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // The count restarts whenever the FSM sits in IDLE, so it is 0 on WAIT entry.
    always_ff @(posedge clk) begin
        if (rst || r_state == ST_IDLE)
            r_wait_cnt <= '0;
        else
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_load_err <= 1'b0;
        else
            r_load_err <= !flush && w_timeout;
    end

    assign wb_load_err = r_load_err;
`else
    assign w_timeout   = 1'b0;
    assign wb_load_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: all clocked state uses non-blocking <= so every register
        // samples pre-edge values and process ordering cannot race.
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would infer a latch.
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_is_load && !dmem_rvalid) w_next_state = ST_WAIT;
                ST_WAIT: if (dmem_rvalid || w_timeout)  w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Output logic: the stall is dropped during a flush, when data arrives,
    // and when the load is abandoned.
    always_comb begin
        mem_stall = 1'b0;
        if (!flush) begin
            case (r_state)
                ST_IDLE: mem_stall = w_is_load && !dmem_rvalid;
                ST_WAIT: mem_stall = !dmem_rvalid && !w_timeout;
                default: mem_stall = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (mem_result_src)
            2'b01:   w_idle_data = format_load(mem_funct3, mem_alu_result[1:0], dmem_rdata);
            2'b10:   w_idle_data = mem_pc_plus4;
            default: w_idle_data = mem_alu_result;
        endcase
    end

    // Writeback registers and hold registers. A flush only kills the
    // valid/write qualifiers; data and dest may keep stale values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid       <= 1'b0;
            r_wb_data        <= '0;
            r_wb_reg_dest    <= '0;
            r_wb_reg_write   <= 1'b0;
            r_hold_funct3    <= '0;
            r_hold_offset    <= '0;
            r_hold_dest      <= '0;
            r_hold_reg_write <= 1'b0;
        end else if (flush) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (!mem_valid) begin
                r_wb_valid     <= 1'b0;
                r_wb_reg_write <= 1'b0;
            end else if (w_is_load && !dmem_rvalid) begin
                r_wb_valid       <= 1'b0;
                r_wb_reg_write   <= 1'b0;
                r_hold_funct3    <= mem_funct3;
                r_hold_offset    <= mem_alu_result[1:0];
                r_hold_dest      <= mem_reg_dest;
                r_hold_reg_write <= mem_reg_write && (mem_reg_dest != '0);
            end else begin
                r_wb_valid     <= 1'b1;
                r_wb_data      <= w_idle_data;
                r_wb_reg_dest  <= mem_reg_dest;
                r_wb_reg_write <= mem_reg_write && (mem_reg_dest != '0);
            end
        end else begin
            // WAIT: MEM inputs are ignored; only the hold registers matter.
            if (dmem_rvalid) begin
                r_wb_valid     <= 1'b1;
                r_wb_data      <= format_load(r_hold_funct3, r_hold_offset, dmem_rdata);
                r_wb_reg_dest  <= r_hold_dest;
                r_wb_reg_write <= r_hold_reg_write;
            end else begin
                r_wb_valid     <= 1'b0;
                r_wb_reg_write <= 1'b0;
            end
        end
    end

    assign wb_valid     = r_wb_valid;
    assign wb_data      = r_wb_data;
    assign wb_reg_dest  = r_wb_reg_dest;
    assign wb_reg_write = r_wb_reg_write;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage. The DUT is built with
// TIMEOUT_CYCLES=4; the timeout scenario runs only when LOAD_TIMEOUT_EN is
// defined for both the bench and the RTL.

module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          mem_valid;
    logic [DW-1:0] mem_alu_result;
    logic [DW-1:0] mem_pc_plus4;
    logic [1:0]    mem_result_src;
    logic [2:0]    mem_funct3;
    logic [AW-1:0] mem_reg_dest;
    logic          mem_reg_write;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_rvalid;
    logic          mem_stall;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] wb_reg_dest;
    logic          wb_reg_write;
    logic          wb_load_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_alu_result(mem_alu_result),
        .mem_pc_plus4  (mem_pc_plus4),
        .mem_result_src(mem_result_src),
        .mem_funct3    (mem_funct3),
        .mem_reg_dest  (mem_reg_dest),
        .mem_reg_write (mem_reg_write),
        .dmem_rdata    (dmem_rdata),
        .dmem_rvalid   (dmem_rvalid),
        .mem_stall     (mem_stall),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_reg_dest   (wb_reg_dest),
        .wb_reg_write  (wb_reg_write),
        .wb_load_err   (wb_load_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 unit later, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [2:0] f3, input logic [4:0] dest,
                         input logic rw, input logic [31:0] rdata, input logic rvalid);
        mem_valid      = v;
        mem_result_src = src;
        mem_alu_result = alu;
        mem_pc_plus4   = pc;
        mem_funct3     = f3;
        mem_reg_dest   = dest;
        mem_reg_write  = rw;
        dmem_rdata     = rdata;
        dmem_rvalid    = rvalid;
        #1;
    endtask

    task automatic load_now(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
        drive(1'b1, 2'b01, addr, 32'h0, f3, 5'd3, 1'b1, 32'h80FF7F01, 1'b1);
        check({tag, "_stall"}, 32'(mem_stall), 32'd0);
        tick();
        check({tag, "_data"}, wb_data, exp);
        check({tag, "_valid"}, 32'(wb_valid), 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        check("rst_valid", 32'(wb_valid), 32'd0);
        check("rst_data", wb_data, 32'd0);
        check("rst_dest", 32'(wb_reg_dest), 32'd0);
        check("rst_write", 32'(wb_reg_write), 32'd0);
        check("rst_err", 32'(wb_load_err), 32'd0);
        rst = 1'b0;

        // Reset held 2 cycles while a load waits.
        drive(1'b1, 2'b01, 32'h200, 32'h0, 3'b010, 5'd4, 1'b1, 32'h0, 1'b0);
        check("midwait_stall_req", 32'(mem_stall), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("midwait_rst_valid", 32'(wb_valid), 32'd0);
        check("midwait_rst_write", 32'(wb_reg_write), 32'd0);
        check("midwait_rst_data", wb_data, 32'd0);
        rst = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 32'h0, 1'b0);
        check("midwait_rel_stall", 32'(mem_stall), 32'd0);

        // ALU op to x5, then to x0.
        drive(1'b1, 2'b00, 32'h1234, 32'h0, 3'b000, 5'd5, 1'b1, 32'h0, 1'b0);
        check("alu_stall", 32'(mem_stall), 32'd0);
        tick();
        check("alu_data", wb_data, 32'h1234);
        check("alu_valid", 32'(wb_valid), 32'd1);
        check("alu_write", 32'(wb_reg_write), 32'd1);
        check("alu_dest", 32'(wb_reg_dest), 32'd5);
        drive(1'b1, 2'b00, 32'h1234, 32'h0, 3'b000, 5'd0, 1'b1, 32'h0, 1'b0);
        tick();
        check("x0_valid", 32'(wb_valid), 32'd1);
        check("x0_write", 32'(wb_reg_write), 32'd0);

        // Select code 11 behaves as ALU; rvalid ignored for non-loads.
        drive(1'b1, 2'b11, 32'hA5A5_0001, 32'h44, 3'b000, 5'd6, 1'b1, 32'hDEAD_BEEF, 1'b1);
        tick();
        check("src11_data", wb_data, 32'hA5A5_0001);

        // Bubble.
        drive(1'b0, 2'b00, 32'h99, 32'h0, 3'b000, 5'd5, 1'b1, 32'h0, 1'b0);
        tick();
        check("bubble_valid", 32'(wb_valid), 32'd0);
        check("bubble_write", 32'(wb_reg_write), 32'd0);

        // Back-to-back immediate loads on 0x80FF7F01.
        load_now("lb_o0",  3'b000, 32'h1000, 32'h0000_0001);
        load_now("lb_o1",  3'b000, 32'h1001, 32'h0000_007F);
        load_now("lb_o2",  3'b000, 32'h1002, 32'hFFFF_FFFF);
        load_now("lb_o3",  3'b000, 32'h1003, 32'hFFFF_FF80);
        load_now("lbu_o3", 3'b100, 32'h1003, 32'h0000_0080);
        load_now("lbu_o2", 3'b100, 32'h1002, 32'h0000_00FF);
        load_now("lh_a2",  3'b001, 32'h1002, 32'hFFFF_80FF);
        load_now("lh_a3",  3'b001, 32'h1003, 32'hFFFF_80FF);
        load_now("lh_a0",  3'b001, 32'h1000, 32'h0000_7F01);
        load_now("lhu_a0", 3'b101, 32'h1000, 32'h0000_7F01);
        load_now("lhu_a2", 3'b101, 32'h1002, 32'h0000_80FF);
        load_now("lw",     3'b010, 32'h1000, 32'h80FF_7F01);
        load_now("f3_111", 3'b111, 32'h1001, 32'h80FF_7F01);
        check("load_write", 32'(wb_reg_write), 32'd1);

        // Load with data three cycles late; MEM inputs changed while waiting
        // must not matter. PC+4 instruction follows.
        drive(1'b1, 2'b01, 32'h100, 32'h0, 3'b010, 5'd7, 1'b1, 32'h0, 1'b0);
        check("dly_stall_c0", 32'(mem_stall), 32'd1);
        tick();
        check("dly_bubble_valid", 32'(wb_valid), 32'd0);
        check("dly_bubble_write", 32'(wb_reg_write), 32'd0);
        drive(1'b1, 2'b01, 32'h103, 32'h0, 3'b000, 5'd9, 1'b1, 32'h0, 1'b0);
        check("dly_stall_c1", 32'(mem_stall), 32'd1);
        tick();
        check("dly_stall_c2", 32'(mem_stall), 32'd1);
        tick();
        drive(1'b1, 2'b01, 32'h103, 32'h0, 3'b000, 5'd9, 1'b1, 32'hCAFE_F00D, 1'b1);
        check("dly_stall_c3", 32'(mem_stall), 32'd0);
        tick();
        check("dly_data", wb_data, 32'hCAFE_F00D);
        check("dly_valid", 32'(wb_valid), 32'd1);
        check("dly_dest", 32'(wb_reg_dest), 32'd7);
        check("dly_write", 32'(wb_reg_write), 32'd1);
        drive(1'b1, 2'b10, 32'h55, 32'h104, 3'b000, 5'd1, 1'b1, 32'h0, 1'b0);
        check("pc4_stall", 32'(mem_stall), 32'd0);
        tick();
        check("pc4_data", wb_data, 32'h104);
        check("pc4_valid", 32'(wb_valid), 32'd1);
        check("pc4_dest", 32'(wb_reg_dest), 32'd1);

        // Flush in WAIT with rvalid in the same cycle.
        drive(1'b1, 2'b01, 32'h300, 32'h0, 3'b010, 5'd8, 1'b1, 32'h0, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'b01, 32'h300, 32'h0, 3'b010, 5'd8, 1'b1, 32'h1111_2222, 1'b1);
        check("flush_stall", 32'(mem_stall), 32'd0);
        tick();
        flush = 1'b0;
        check("flush_valid", 32'(wb_valid), 32'd0);
        check("flush_write", 32'(wb_reg_write), 32'd0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 32'h0, 1'b0);
        check("flush_idle_stall", 32'(mem_stall), 32'd0);
        tick();
        check("flush_idle_valid", 32'(wb_valid), 32'd0);

        // Flush in IDLE kills an ALU op.
        flush = 1'b1;
        drive(1'b1, 2'b00, 32'h77, 32'h0, 3'b000, 5'd2, 1'b1, 32'h0, 1'b0);
        tick();
        flush = 1'b0;
        check("flush_alu_valid", 32'(wb_valid), 32'd0);
        check("flush_alu_write", 32'(wb_reg_write), 32'd0);

`ifdef LOAD_TIMEOUT_EN
        // Load that never gets data: 4 WAIT cycles, stall drops in the 4th.
        drive(1'b1, 2'b01, 32'h400, 32'h0, 3'b010, 5'd10, 1'b1, 32'h0, 1'b0);
        check("to_stall_req", 32'(mem_stall), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("to_stall_w%0d", i), 32'(mem_stall), 32'd1);
            check($sformatf("to_err_w%0d", i), 32'(wb_load_err), 32'd0);
            tick();
        end
        check("to_stall_w3", 32'(mem_stall), 32'd0);
        tick();
        check("to_err_pulse", 32'(wb_load_err), 32'd1);
        check("to_write", 32'(wb_reg_write), 32'd0);
        check("to_valid", 32'(wb_valid), 32'd0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 32'h0, 1'b1);
        check("to_idle_stall", 32'(mem_stall), 32'd0);
        tick();
        check("to_err_clear", 32'(wb_load_err), 32'd0);
        check("to_late_valid", 32'(wb_valid), 32'd0);
`else
        check("no_timeout_err", 32'(wb_load_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline register stage.
- Selects the writeback source from an explicit result-select code: ALU, load or PC+4.
- Formats load data by size, sign and byte offset.
- Tolerates variable-latency data memory with a valid handshake, stalling upstream until load data returns.
- Sits between the data-memory interface and the register-file write port. Its registered outputs also feed the forwarding unit.

Parameters:
DATA_WIDTH, 32, datapath width; load formatting is defined for 32 only.
REG_ADDR_WIDTH, 5, register index width.
TIMEOUT_CYCLES, 16, WAIT-state cycles before a load is abandoned (used only with LOAD_TIMEOUT_EN).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill the instruction in MEM and any pending load
mem_valid  in  1  an instruction is present in MEM
mem_alu_result  in  DATA_WIDTH  ALU result; also the load address, low 2 bits are the byte offset
mem_pc_plus4  in  DATA_WIDTH  return address for JAL/JALR
mem_result_src  in  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU
mem_funct3  in  3  load type
mem_reg_dest  in  REG_ADDR_WIDTH  destination register
mem_reg_write  in  1  register write enable
dmem_rdata  in  DATA_WIDTH  read data word from memory
dmem_rvalid  in  1  read data valid this cycle
mem_stall  out  1  combinational; hold IF..MEM this cycle
wb_valid  out  1  wb_* holds a retiring instruction
wb_data  out  DATA_WIDTH  writeback data
wb_reg_dest  out  REG_ADDR_WIDTH  destination register
wb_reg_write  out  1  qualified write enable
wb_load_err  out  1  one-cycle pulse on load timeout (LOAD_TIMEOUT_EN only, else tied 0)

Behaviour:
- Priority: rst > flush > normal operation.
- Reset: state=IDLE; wb_valid, wb_data, wb_reg_dest, wb_reg_write, wb_load_err, hold registers and counter all 0.
- wb_reg_write = registered (mem_reg_write & accepted & dest!=0). Writes to x0 are never asserted.
- FSM IDLE:
  - mem_valid=0 → bubble: wb_valid=0, wb_reg_write=0.
  - Non-load → next edge: wb_data = ALU result or PC+4; wb_valid=1. Latency 1 cycle.
  - Load with dmem_rvalid=1 in the same cycle → formatted data registered next edge.
  - Load with dmem_rvalid=0 → capture funct3, byte offset, dest and reg_write into hold registers; mem_stall=1; next state WAIT; insert bubble (wb_valid=0).
- FSM WAIT:
  - mem_stall = !dmem_rvalid (combinational).
  - On dmem_rvalid → register formatted data from the hold registers; wb_valid=1; return to IDLE. Upstream advances that same cycle.
  - MEM inputs are ignored in WAIT; they are held by the stall.
- Load format on dmem_rdata, offset o=addr[1:0]:
  - 000 LB: byte o, sign-extended.
  - 100 LBU: byte o, zero-extended.
  - 001 LH: half addr[1], sign-extended; addr[0] ignored.
  - 101 LHU: half addr[1], zero-extended; addr[0] ignored.
  - 010 LW: full word.
  - Any other funct3: full word.
- Flush: next edge clears wb_valid and wb_reg_write and forces IDLE; mem_stall=0 that cycle. A dmem_rvalid arriving in the same cycle as flush is dropped. wb_data/wb_reg_dest may hold stale values but are never written.
- Back-to-back loads each returning rvalid the same cycle → one retire per cycle, no stall.

Optional Feature:
LOAD_TIMEOUT_EN:
- Defined:
  - Cycle counter resets on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no rvalid: wb_load_err pulses 1 for one cycle; load is dropped (wb_reg_write=0); return to IDLE; mem_stall drops that cycle.
  - A late rvalid in IDLE with no load request is ignored.
- Undefined: WAIT persists indefinitely; wb_load_err is constant 0.

Test Plan:
- Reset held 2 cycles mid-WAIT → all outputs 0, state IDLE, mem_stall=0 after release.
- ALU op, dest=x5, alu_result=0x1234 → one cycle later wb_data=0x1234, wb_reg_write=1, wb_valid=1; same op with dest=x0 → wb_reg_write=0, wb_valid=1.
- LB/LBU/LH/LHU/LW with dmem_rdata=0x80FF7F01 at offsets 0..3, immediate rvalid → LB o1=0x0000007F, o2=0xFFFFFFFF, o3=0xFFFFFF80; LBU o3=0x00000080; LH addr[1]=1 → 0xFFFF80FF; LHU addr[1]=0 → 0x00007F01; LW=0x80FF7F01.
- Load with rvalid delayed 3 cycles, PC+4 instruction (0x104) queued behind it → mem_stall high exactly 3 cycles, load retires, PC+4 instruction retires next cycle with wb_data=0x104.
- Flush asserted in WAIT, rvalid same cycle → no write, IDLE next cycle.
- LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4, rvalid never arrives → wb_load_err single pulse, no write, stall released.
